// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO, programmable baud divisor, 8N1 framing.
// busy stalls the core on a TXDATA store while the FIFO is full.
module uart_tx_mmio #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wmem,
  input  logic        rmem,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        busy,
  output logic        uart_tx
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [15:0]   div_reg;

  logic [1:0]  state, state_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [15:0] bit_div, bit_div_nxt;
  logic [15:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        tx_nxt;

  logic [1:0]  offset;
  logic        full, empty, wr_txdata, push, pop, tx_active;
  logic [15:0] div_eff;
  logic [3:0]  cnt_sat;
  logic [31:0] rdata_nxt;
  logic        unused_bits;

  assign unused_bits = ^{mem_wdata[31:16], mem_addr[1:0]};

  assign offset    = mem_addr[3:2];
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign wr_txdata = sel & wmem & (offset == OFF_TXDATA);
  assign busy      = wr_txdata & full & ~rst;
  assign push      = wr_txdata & ~full;
  assign tx_active = (state != S_IDLE);
  assign div_eff   = (div_reg < 16'd2) ? 16'd2 : div_reg;
  assign cnt_sat   = (32'(count) > 32'd15) ? 4'd15 : 4'(count);

  // FIFO pointers and occupancy; push never relies on a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= 16'(CLK_DIV);
    end else if (sel && wmem && (offset == OFF_DIV)) begin
      div_reg <= mem_wdata[15:0];
    end
  end

  always_comb begin
    rdata_nxt = '0;
    case (offset)
      OFF_STATUS: rdata_nxt = {24'd0, cnt_sat, 1'b0, tx_active, empty, full};
      OFF_DIV:    rdata_nxt = {16'd0, div_reg};
      default:    rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= '0;
    end else if (sel && rmem) begin
      mem_rdata <= rdata_nxt;
    end
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      uart_tx  <= 1'b1;
      shreg    <= '0;
      bit_div  <= 16'd2;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      uart_tx  <= tx_nxt;
      shreg    <= shreg_nxt;
      bit_div  <= bit_div_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
    end
  end

  // Frame sequencing; the divisor is latched per frame so DIV writes apply to the next byte
  always_comb begin
    state_nxt    = state;
    tx_nxt       = uart_tx;
    shreg_nxt    = shreg;
    bit_div_nxt  = bit_div;
    baud_cnt_nxt = baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    pop          = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!empty) begin
          pop          = 1'b1;
          shreg_nxt    = fifo_mem[rptr];
          bit_div_nxt  = div_eff;
          baud_cnt_nxt = div_eff - 16'd1;
          tx_nxt       = 1'b0;
          state_nxt    = S_START;
        end
      end
      S_START: begin
        if (baud_cnt == '0) begin
          baud_cnt_nxt = bit_div - 16'd1;
          bit_cnt_nxt  = '0;
          tx_nxt       = shreg[0];
          shreg_nxt    = {1'b0, shreg[7:1]};
          state_nxt    = S_DATA;
        end else begin
          baud_cnt_nxt = baud_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_cnt == '0) begin
          baud_cnt_nxt = bit_div - 16'd1;
          if (bit_cnt == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = S_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            tx_nxt      = shreg[0];
            shreg_nxt   = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_cnt_nxt = baud_cnt - 16'd1;
        end
      end
      S_STOP: begin
        tx_nxt = 1'b1;
        if (baud_cnt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          baud_cnt_nxt = baud_cnt - 16'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: stores push expected bytes into a queue,
// a serial-line monitor decodes each frame at the expected bit time and checks it.
module tb_uart_tx_mmio;
  logic        clk = 1'b0;
  logic        rst, sel, wmem, rmem;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy, uart_tx;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  int model_div = 868;
  bit mon_busy = 1'b0;
  bit gap_arm = 1'b0;
  int gap = 0;
  int max_gap = 0;

  uart_tx_mmio dut (
    .clk(clk), .rst(rst), .sel(sel), .wmem(wmem), .rmem(rmem),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; rmem = 1'b1; mem_addr = a;
    @(posedge clk); #1;
    sel = 1'b0; rmem = 1'b0;
    d = mem_rdata;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, output int stalls);
    logic st;
    sel = 1'b1; wmem = 1'b1; mem_addr = a; mem_wdata = d; stalls = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      st = busy;
      @(posedge clk);
      if (!st) break;
      stalls++;
    end
    #1;
    sel = 1'b0; wmem = 1'b0;
    if (stalls == 3000) chk("store_timeout", 32'(stalls), 32'd0);
    else if (a[3:2] == 2'd0) sb.push_back(d[7:0]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 6000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 6000), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Serial monitor: decodes one frame per falling start edge at the model's bit time
  initial begin : monitor
    logic [9:0] obs;
    logic [9:0] exp;
    logic stable, abort;
    int d;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || uart_tx !== 1'b0) begin
        gap++;
      end else begin
        if (gap_arm && gap > max_gap) max_gap = gap;
        d = (model_div < 2) ? 2 : model_div;
        mon_busy = 1'b1; stable = 1'b1; abort = 1'b0; obs = '0;
        for (int i = 0; i < 10 * d; i++) begin
          if (i != 0) @(negedge clk);
          if (rst !== 1'b0) begin
            abort = 1'b1;
            break;
          end
          if (i % d == 0) obs[i / d] = uart_tx;
          else if (uart_tx !== obs[i / d]) stable = 1'b0;
        end
        if (!abort) begin
          chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp = {1'b1, sb.pop_front(), 1'b0};
            chk("frame", 32'(obs), 32'(exp));
            chk("bit_timing", 32'(stable), 32'd1);
          end
          gap_arm = 1'b1;
        end
        gap = 0;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, total;
    logic [31:0] d;
    rst = 1'b1; sel = 1'b0; wmem = 1'b0; rmem = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    rst = 1'b0;

    rd(4'h4, d); chk("status_reset", d, 32'h02);
    rd(4'h8, d); chk("div_reset", d, 32'd868);
    rd(4'h0, d); chk("rd_txdata_zero", d, 32'd0);
    rd(4'h8, d);
    rd(4'hC, d); chk("rd_reserved_zero", d, 32'd0);
    wr(4'hC, 32'h55, st);
    rd(4'h8, d); chk("div_after_reserved_wr", d, 32'd868);
    rd(4'h4, d); chk("status_after_reserved_wr", d, 32'h02);

    // DIV=4, 0xA5 with one-cycle start latency
    wr(4'h8, 32'd4, st); model_div = 4;
    rd(4'h8, d); chk("div_rb4", d, 32'd4);
    wr(4'h0, 32'hA5, st);
    chk("lat_edge_k", 32'(uart_tx), 32'd1);
    @(posedge clk); #1;
    chk("lat_edge_k1", 32'(uart_tx), 32'd0);
    rd(4'h4, d); chk("status_active", d, 32'h06);
    wait_idle("a5");
    rd(4'h4, d); chk("status_idle", d, 32'h02);

    // DIV=0 is clamped to a two-cycle bit
    wr(4'h8, 32'd0, st); model_div = 0;
    rd(4'h8, d); chk("div_rb0", d, 32'd0);
    wr(4'h0, 32'h3C, st);
    wait_idle("div0");

    // Burst of nine fills the FIFO; the tenth store stalls
    wr(4'h8, 32'd16, st); model_div = 16;
    gap_arm = 1'b0; max_gap = 0; total = 0;
    for (int i = 0; i < 9; i++) begin
      wr(4'h0, 32'(8'h31 + 8'(i * 7)), st);
      total += st;
    end
    chk("burst_no_stall", 32'(total), 32'd0);
    rd(4'h4, d); chk("status_full", d, 32'h85);
    wr(4'h4, 32'hFF, st); chk("status_store_no_stall", 32'(st), 32'd0);
    sel = 1'b1; wmem = 1'b1; mem_addr = 4'h4; #1;
    chk("busy_status_store", 32'(busy), 32'd0);
    mem_addr = 4'hC; #1;
    chk("busy_reserved_store", 32'(busy), 32'd0);
    mem_addr = 4'h0; #1;
    chk("busy_full_txdata", 32'(busy), 32'd1);
    sel = 1'b0; wmem = 1'b0;
    rd(4'h4, d); chk("status_unchanged", d, 32'h85);
    wr(4'h0, 32'hE7, st); chk("tenth_stalled", 32'(st > 0), 32'd1);
    wait_idle("burst");
    chk("burst_gap", 32'(max_gap <= 1), 32'd1);

    // DIV change mid-frame applies to the following frame
    wr(4'h8, 32'd8, st); model_div = 8;
    wr(4'h0, 32'h5A, st);
    wr(4'h0, 32'hC3, st);
    repeat (20) @(posedge clk);
    #1;
    wr(4'h8, 32'd2, st); model_div = 2;
    rd(4'h8, d); chk("div_rb2", d, 32'd2);
    wait_idle("div_change");

    // Reset during DATA with bytes queued, colliding with a DIV store
    wr(4'h8, 32'd8, st); model_div = 8;
    wr(4'h0, 32'h11, st);
    wr(4'h0, 32'h22, st);
    wr(4'h0, 32'h33, st);
    wr(4'h0, 32'h44, st);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_frame_active", 32'(mon_busy), 32'd1);
    rst = 1'b1; sel = 1'b1; wmem = 1'b1; mem_addr = 4'h8; mem_wdata = 32'd3;
    @(posedge clk); #1;
    chk("rst_abort_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy_mid", 32'(busy), 32'd0);
    rst = 1'b0; sel = 1'b0; wmem = 1'b0;
    sb.delete();
    model_div = 868;
    rd(4'h4, d); chk("status_after_rst", d, 32'h02);
    rd(4'h8, d); chk("div_after_rst", d, 32'd868);
    repeat (30) @(posedge clk);
    #1;
    chk("no_frame_after_rst", 32'(mon_busy), 32'd0);
    chk("line_idle_after_rst", 32'(uart_tx), 32'd1);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
